// File: rtl/cdc_hs_pkg.sv
// Shared state encoding for the 4-phase req/ack handshake blocks (tx now, rx later).
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_IDLE    = 2'd1,
        ST_REQ     = 2'd2
    } hs_state_e;

endpackage

// File: rtl/clk_sync.sv
// Plain multi-flop synchronizer for a single asynchronous level; deliberately not reset.
module clk_sync #(
    parameter int STAGES = 3
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge i_clk) begin
        sync_ff <= {sync_ff[STAGES-2:0], i_d};
    end

    assign o_q = sync_ff[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Outbound 4-phase req/ack CDC sender with a local valid/ready stream.
// Optional REQ abort timer enabled by defining CDC_HS_TX_TIMEOUT_EN.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_req,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ack,
    output logic             o_timeout
);

    hs_state_e        state, state_n;
    logic             req_n, ready_n;
    logic [WIDTH-1:0] data_n;
    logic             ack_s;

    clk_sync #(.STAGES(STAGES)) u_ack_sync (
        .i_clk (i_clk),
        .i_d   (i_ack),
        .o_q   (ack_s)
    );

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_n;
`endif

    // Reset lands in RELEASE because the unreset synchronizer may still show a stale ack.
    always_comb begin
        state_n = state;
        req_n   = o_req;
        ready_n = o_ready;
        data_n  = o_data;
`ifdef CDC_HS_TX_TIMEOUT_EN
        cnt_n     = cnt;
        timeout_n = 1'b0;
`endif
        case (state)
            ST_RELEASE: begin
                req_n   = 1'b0;
                ready_n = 1'b0;
                if (!ack_s) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                end
            end
            ST_IDLE: begin
                ready_n = 1'b1;
                if (i_valid && o_ready) begin
                    data_n  = i_data;
                    req_n   = 1'b1;
                    ready_n = 1'b0;
                    state_n = ST_REQ;
`ifdef CDC_HS_TX_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_n   = 1'b0;
                    state_n = ST_RELEASE;
                end
`ifdef CDC_HS_TX_TIMEOUT_EN
                // Ack arriving on the final cycle still counts as a normal completion.
                else if (cnt == CNT_LAST) begin
                    req_n     = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = ST_RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_n = ST_RELEASE;
                req_n   = 1'b0;
                ready_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_RELEASE;
            o_req   <= 1'b0;
            o_ready <= 1'b0;
            o_data  <= '0;
        end else begin
            state   <= state_n;
            o_req   <= req_n;
            o_ready <= ready_n;
            o_data  <= data_n;
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            o_timeout <= timeout_n;
        end
    end
`else
    // TIMEOUT only matters when the abort timer is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign o_timeout          = 1'b0;
`endif

endmodule
